inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Parametrised successor to the single-shot instruction front end of the Frodo accelerator.
- Accepts packed instructions over a valid/ready handshake and queues them in a FIFO.
- Executes them in order:
  - Transfer opcodes expand into address bursts on a selectable memory port.
  - Compute opcodes issue a start pulse to the arithmetic core and wait for its done.
- Sits between the host instruction interface and the memory-port / compute-core control inside the top level.

Parameters:
- INST_WIDTH, 27, instruction word width.
- ADDR_WIDTH, 12, memory address width.
- LEN_WIDTH, 6, burst length field width.
- PORT_NUM, 4, number of memory ports. Port field width PW = clog2(PORT_NUM).
- FIFO_DEPTH, 4, instruction queue depth. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  INST_WIDTH  instruction word.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  queue can accept (= !full).
- mem_valid  out  1  burst beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_we  out  1  1 = store, 0 = load.
- mem_port_en  out  PORT_NUM  one-hot port select, valid with mem_valid.
- mem_last  out  1  final beat of burst.
- op_start  out  1  one-cycle compute start pulse.
- op_code  out  3  compute opcode.
- op_a, op_b, op_c  out  4 each  operand/result buffer indices.
- op_mode  out  1  compute mode.
- op_done  in  1  compute completion pulse.
- busy  out  1  FSM not IDLE or queue non-empty.
- err_illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - All outputs 0, except inst_ready = 1.
  - FIFO empty, FSM in IDLE, err_illegal cleared.
  - Reset mid-burst or mid-compute aborts immediately and discards all queued instructions.
- Field layout (MSB first):
  - Transfer: {opcode[2:0], addr[ADDR_WIDTH], len[LEN_WIDTH], port[PW], pad}.
  - Compute: {opcode[2:0], A[4], B[4], C[4], mode, pad}.
  - Pad bits are ignored.
- Opcodes:
  - 000 = load.
  - 001 = store.
  - 100, 101, 110 = compute.
  - All others illegal.
- Push: an instruction is written on any edge where inst_valid && inst_ready.
- Pop: happens on the edge where FSM is IDLE and FIFO is non-empty.
  - Push and pop in the same cycle are allowed whenever the FIFO is neither full nor empty.
  - No push is possible while full.
- FSM states and transitions:
  - IDLE, on pop:
    - Transfer with len ≠ 0 → XFER. Latch addr, len, port, we.
    - Transfer with len = 0 → stays IDLE; instruction retired with no beats.
    - Compute → EXEC. op_start = 1 for exactly the next cycle; op_* fields latched and held until return to IDLE.
    - Illegal → set err_illegal, discard, stay IDLE.
  - XFER:
    - mem_valid = 1 and mem_port_en = 1 << port.
    - mem_addr starts at addr and increments by 1 on each accepted beat (mem_valid && mem_ready).
    - Address wraps modulo 2^ADDR_WIDTH (e.g. 4094 len 4 → 4094, 4095, 0, 1).
    - mem_last = 1 when remaining beats = 1.
    - On an accepted last beat → IDLE.
    - With mem_ready low, address/last/port are held stable.
  - EXEC:
    - Waits for op_done, then → IDLE.
    - op_done outside EXEC is ignored.
    - op_done in the same cycle as op_start is accepted.
- Latency: instruction accepted at edge E0 into an empty queue with FSM idle → popped at E1 → first beat (or op_start) visible in the cycle after E1.
- Back-to-back: at least one IDLE cycle between consecutive instructions.
- err_illegal is cleared only by rst.

Test Plan:
- Load addr=100, len=4, port=0, mem_ready tied 1:
  - Beats 100, 101, 102, 103 on consecutive cycles.
  - mem_port_en=0001, mem_we=0.
  - mem_last only on 103.
  - First beat 2 cycles after the accepting edge.
- Store addr=200, len=2, port=2, with mem_ready low for 3 cycles on the first beat:
  - mem_addr holds at 200 while stalled, then 201 with last.
  - mem_port_en=0100, mem_we=1.
- Wrap: addr=4094, len=4 → 4094, 4095, 0, 1.
- Len 0 followed by load addr=10 len=1:
  - No beat for the first instruction.
  - Single beat at 10 with mem_last.
- Compute 100 (A=1, B=2, C=3, mode=0), op_done after 20 cycles:
  - One op_start pulse with fields 1/2/3.
  - A following queued load starts only after op_done.
- Push 6 instructions while the first compute waits:
  - inst_ready drops after 4 are queued.
- Opcode 111 sets err_illegal and the next instruction still executes.
- Assert rst mid-burst: outputs zero immediately and the queue is empty after release.

Source files
------------

// File: rtl/inst_sequencer_if.sv
// Host-instruction, memory-burst and compute-control signals of inst_sequencer.
// master: the sequencer (takes instructions, drives bursts and compute control).
// slave:  the environment (host, memory ports, arithmetic core).
interface inst_sequencer_if #(
  parameter int INST_WIDTH = 27,
  parameter int ADDR_WIDTH = 12,
  parameter int PORT_NUM   = 4
);
  // instruction intake
  logic [INST_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  inst_ready;
  // memory burst
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [PORT_NUM-1:0]   mem_port_en;
  logic                  mem_last;
  // compute core control
  logic                  op_start;
  logic [2:0]            op_code;
  logic [3:0]            op_a;
  logic [3:0]            op_b;
  logic [3:0]            op_c;
  logic                  op_mode;
  logic                  op_done;
  // status
  logic                  busy;
  logic                  err_illegal;

  modport master (
    input  inst, inst_valid, mem_ready, op_done,
    output inst_ready, mem_valid, mem_addr, mem_we, mem_port_en, mem_last,
    output op_start, op_code, op_a, op_b, op_c, op_mode, busy, err_illegal
  );

  modport slave (
    output inst, inst_valid, mem_ready, op_done,
    input  inst_ready, mem_valid, mem_addr, mem_we, mem_port_en, mem_last,
    input  op_start, op_code, op_a, op_b, op_c, op_mode, busy, err_illegal
  );
endinterface

// File: rtl/inst_sequencer.sv
// Purpose: queue packed instructions and run them in order as memory bursts or compute jobs.
// Latency: instruction accepted at edge E0 into an idle, empty sequencer is popped at E1;
//          its first beat / op_start is visible in the cycle after E1.
// Backpressure: inst_ready = !full; a burst beat advances only on mem_valid && mem_ready.
// Ports: clk, rst (async, active-high); bus (inst_sequencer_if.master) carries
//        inst/inst_valid/inst_ready, mem_* burst signals, op_* compute control, busy, err_illegal.
module inst_sequencer #(
  parameter int INST_WIDTH = 27,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 6,
  parameter int PORT_NUM   = 4,
  parameter int FIFO_DEPTH = 4   // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  inst_sequencer_if.master bus
);
  localparam int PW     = $clog2(PORT_NUM);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // Bits below the transfer port field are pad in both layouts, so they are never stored.
  localparam int PAD_W  = INST_WIDTH - 3 - ADDR_WIDTH - LEN_WIDTH - PW;
  localparam int USED_W = INST_WIDTH - PAD_W;

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_EXEC} state_t;

  // ---------------- instruction queue ----------------
  logic [USED_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              fifo_full, fifo_empty, push, pop;
  logic [USED_W-1:0] head;
  logic              inst_pad_unused;

  state_t state_q, state_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // Extra MSB on the pointers distinguishes full from empty when the indices match.
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = bus.inst_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign inst_pad_unused = ^bus.inst[PAD_W-1:0];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.inst[INST_WIDTH-1:PAD_W];
  end

  // ---------------- head decode ----------------
  logic [2:0]            hd_opc;
  logic [ADDR_WIDTH-1:0] hd_addr;
  logic [LEN_WIDTH-1:0]  hd_len;
  logic [PW-1:0]         hd_port;
  logic [3:0]            hd_a, hd_b, hd_c;
  logic                  hd_mode, hd_is_xfer, hd_is_comp;

  assign hd_opc     = head[USED_W-1 -: 3];
  assign hd_addr    = head[USED_W-4 -: ADDR_WIDTH];
  assign hd_len     = head[USED_W-4-ADDR_WIDTH -: LEN_WIDTH];
  assign hd_port    = head[PW-1:0];
  assign hd_a       = head[USED_W-4 -: 4];
  assign hd_b       = head[USED_W-8 -: 4];
  assign hd_c       = head[USED_W-12 -: 4];
  assign hd_mode    = head[USED_W-16];
  assign hd_is_xfer = (hd_opc == 3'b000) || (hd_opc == 3'b001);
  assign hd_is_comp = (hd_opc == 3'b100) || (hd_opc == 3'b101) || (hd_opc == 3'b110);

  // ---------------- sequencer state ----------------
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [PW-1:0]         port_q, port_d;
  logic                  we_q, we_d;
  logic                  op_start_q, op_start_d;
  logic [2:0]            op_code_q, op_code_d;
  logic [3:0]            op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic                  op_mode_q, op_mode_d;
  logic                  err_q, err_d;
  logic                  beat_acc;

  assign beat_acc = (state_q == S_XFER) && bus.mem_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    port_d     = port_q;
    we_d       = we_q;
    op_start_d = 1'b0;
    op_code_d  = op_code_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_c_d     = op_c_q;
    op_mode_d  = op_mode_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (hd_is_xfer) begin
            // A zero-length transfer retires here without producing any beat.
            if (hd_len != '0) begin
              state_d = S_XFER;
              addr_d  = hd_addr;
              rem_d   = hd_len;
              port_d  = hd_port;
              we_d    = hd_opc[0];
            end
          end else if (hd_is_comp) begin
            state_d    = S_EXEC;
            op_start_d = 1'b1;
            op_code_d  = hd_opc;
            op_a_d     = hd_a;
            op_b_d     = hd_b;
            op_c_d     = hd_c;
            op_mode_d  = hd_mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_XFER: begin
        if (beat_acc) begin
          addr_d = addr_q + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        // op_done is honoured from the op_start cycle onward.
        if (bus.op_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      port_q     <= '0;
      we_q       <= 1'b0;
      op_start_q <= 1'b0;
      op_code_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      op_mode_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      port_q     <= port_d;
      we_q       <= we_d;
      op_start_q <= op_start_d;
      op_code_q  <= op_code_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_c_q     <= op_c_d;
      op_mode_q  <= op_mode_d;
      err_q      <= err_d;
    end
  end

  // ---------------- outputs ----------------
  logic mem_valid_w;
  assign mem_valid_w     = (state_q == S_XFER);
  assign bus.inst_ready  = !fifo_full;
  assign bus.mem_valid   = mem_valid_w;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_port_en = mem_valid_w ? (PORT_NUM'(1) << port_q) : '0;
  assign bus.mem_last    = mem_valid_w && (rem_q == LEN_WIDTH'(1));
  assign bus.op_start    = op_start_q;
  assign bus.op_code     = op_code_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.op_c        = op_c_q;
  assign bus.op_mode     = op_mode_q;
  assign bus.busy        = (state_q != S_IDLE) || !fifo_empty;
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: every issued instruction is expanded into its
// expected beats / compute start, and a monitor compares them as the DUT presents them.
module tb_inst_sequencer;
  localparam int IW = 27, AW = 12, LW = 6, PN = 4, FD = 4;

  typedef struct packed {
    logic        is_op;
    logic [11:0] addr;
    logic        we;
    logic [3:0]  pen;
    logic        last;
    logic [2:0]  code;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
    logic        mode;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_sequencer_if #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .PORT_NUM(PN)) bus ();

  inst_sequencer #(
    .INST_WIDTH(IW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .PORT_NUM(PN), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ev_t  exp_q[$];
  bit   err_exp   = 1'b0;
  bit   exec_open = 1'b0;
  int   chk_cnt   = 0;
  int   pass_cnt  = 0;
  int   done_delay = 0;
  bit   rdy_rand = 1'b0;
  logic rdy_man  = 1'b1;
  logic rdy_rnd  = 1'b1;
  logic op_done_r = 1'b0;

  assign bus.mem_ready = rdy_rand ? rdy_rnd : rdy_man;
  assign bus.op_done   = op_done_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Reference model: fields taken straight from the documented bit layout.
  function automatic void model_issue(input logic [IW-1:0] w);
    int opc, addr, len, port;
    ev_t e;
    opc  = int'(w[26:24]);
    addr = int'(w[23:12]);
    len  = int'(w[11:6]);
    port = int'(w[5:4]);
    if (opc == 0 || opc == 1) begin
      for (int i = 0; i < len; i++) begin
        e = '0;
        e.addr = 12'((addr + i) % 4096);
        e.we   = (opc == 1);
        e.pen  = 4'(1 << port);
        e.last = (i == len - 1);
        exp_q.push_back(e);
      end
    end else if (opc >= 4 && opc <= 6) begin
      e = '0;
      e.is_op = 1'b1;
      e.code  = 3'(opc);
      e.a     = w[23:20];
      e.b     = w[19:16];
      e.c     = w[15:12];
      e.mode  = w[11];
      exp_q.push_back(e);
    end else begin
      err_exp = 1'b1;
    end
  endfunction

  function automatic logic [IW-1:0] mk_x(input int opc, input int addr, input int len, input int port);
    return {3'(opc), 12'(addr), 6'(len), 2'(port), 4'($urandom)};
  endfunction

  function automatic logic [IW-1:0] mk_c(input int opc, input int a, input int b, input int c, input int mode);
    return {3'(opc), 4'(a), 4'(b), 4'(c), 1'(mode), 11'($urandom)};
  endfunction

  // Returns at 1 time unit after the accepting edge.
  task automatic send(input logic [IW-1:0] w);
    int n;
    bit ok;
    @(posedge clk); #1;
    model_issue(w);
    bus.inst = w;
    bus.inst_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = bus.inst_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.inst_valid = 1'b0;
    check("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || exp_q.size() != 0) && n < 3000);
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_err"}, 64'(bus.err_illegal), 64'(err_exp));
  endtask

  // Monitor: compares every presented beat / op_start against the scoreboard.
  initial begin
    ev_t a, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.op_start) begin
          a = '0;
          a.is_op = 1'b1;
          a.code = bus.op_code;
          a.a = bus.op_a;
          a.b = bus.op_b;
          a.c = bus.op_c;
          a.mode = bus.op_mode;
          check("sb_op_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_op", 64'(a), 64'(e));
          end
          exec_open = 1'b1;
        end
        if (bus.op_done && exec_open) exec_open = 1'b0;
        if (bus.mem_valid && bus.mem_ready) begin
          a = '0;
          a.addr = bus.mem_addr;
          a.we = bus.mem_we;
          a.pen = bus.mem_port_en;
          a.last = bus.mem_last;
          check("sb_beat_expected", 64'(exp_q.size() != 0), 64'd1);
          check("beat_after_done", 64'(exec_open), 64'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_beat", 64'(a), 64'(e));
          end
        end
      end
    end
  end

  // Compute core stand-in: answers op_start with op_done after done_delay cycles.
  initial begin
    int cnt;
    bit act;
    act = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      op_done_r = 1'b0;
      if (rst) act = 1'b0;
      else begin
        if (bus.op_start) begin
          act = 1'b1;
          cnt = done_delay;
        end
        if (act) begin
          if (cnt == 0) begin
            op_done_r = 1'b1;
            act = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rdy_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached, simulation stopped");
    $fatal(1);
  end

  initial begin
    int n;
    bus.inst = '0;
    bus.inst_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(bus.inst_ready), 64'd1);
    check("reset_outs", 64'({bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_port_en, bus.mem_last,
                              bus.op_start, bus.op_code, bus.op_a, bus.op_b, bus.op_c, bus.op_mode,
                              bus.busy, bus.err_illegal}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load 100 len 4 port 0: first beat in the second cycle after the accepting edge.
    send(mk_x(0, 100, 4, 0));
    @(negedge clk);
    check("lat_gap", 64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    check("lat_first", 64'({bus.mem_valid, bus.mem_addr}), 64'({1'b1, 12'd100}));
    wait_idle("load");

    // Store 200 len 2 port 2, first beat stalled for 3 cycles.
    rdy_man = 1'b0;
    send(mk_x(1, 200, 2, 2));
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({bus.mem_valid, bus.mem_addr, bus.mem_port_en, bus.mem_we, bus.mem_last}),
            64'({1'b1, 12'd200, 4'b0100, 1'b1, 1'b0}));
      @(posedge clk); #1;
    end
    rdy_man = 1'b1;
    wait_idle("stall");

    send(mk_x(0, 4094, 4, 1));
    wait_idle("wrap");

    send(mk_x(0, 55, 0, 3));
    send(mk_x(0, 10, 1, 0));
    wait_idle("len0");

    // Compute with slow done; queue fills behind it.
    done_delay = 20;
    send(mk_c(4, 1, 2, 3, 0));
    n = 0;
    while (!bus.op_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_seen", 64'(bus.op_start), 64'd1);
    for (int k = 0; k < 4; k++) send(mk_x(k % 2, 300 + 8 * k, 2, k));
    @(negedge clk);
    check("full_ready", 64'(bus.inst_ready), 64'd0);
    check("full_busy", 64'(bus.busy), 64'd1);
    done_delay = 0;
    send(mk_c(6, 9, 10, 11, 1));
    send(mk_x(0, 700, 3, 3));
    wait_idle("fill");

    // Illegal opcode then a legal load.
    send(mk_x(7, 1, 1, 1));
    send(mk_x(0, 77, 2, 3));
    wait_idle("illegal");

    // Reset in the middle of a burst with another instruction queued.
    send(mk_x(0, 500, 20, 1));
    send(mk_x(1, 600, 3, 0));
    n = 0;
    while (!bus.mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    err_exp = 1'b0;
    exec_open = 1'b0;
    #1;
    check("rst_outs", 64'({bus.mem_valid, bus.mem_addr, bus.mem_port_en, bus.mem_last, bus.mem_we,
                            bus.op_start, bus.busy, bus.err_illegal}), 64'd0);
    check("rst_ready", 64'(bus.inst_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_empty", 64'({bus.busy, bus.mem_valid}), 64'd0);

    // Randomized mix with random memory backpressure and compute latency.
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int sel, opc;
      sel = $urandom_range(0, 9);
      opc = (sel < 3) ? 0 : (sel < 5) ? 1 : (sel < 8) ? $urandom_range(4, 6) : (sel == 8 ? 2 : 7);
      done_delay = $urandom_range(0, 4);
      if (opc >= 4 && opc <= 6)
        send(mk_c(opc, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1)));
      else
        send(mk_x(opc, $urandom_range(0, 4095), $urandom_range(0, 6), $urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
    end
    wait_idle("rand");
    rdy_rand = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
